// File: rtl/full_adder_if.sv
// rtl/full_adder_if.sv - operand/result bundle for the registered ripple adder
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  s, c, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output s, c, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - registered WIDTH-bit ripple-carry adder built from one-bit cells
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic k,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ k;
  assign co = (a & b) | (a & k) | (b & k);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  full_adder_if.slave  bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             valid_q;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .k  (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Result registers load only on accepted input, so unqualified X/Z never reaches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      c_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s_q <= sum;
        c_q <= carry[WIDTH];
      end
    end
  end

  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - scoreboard bench driving WIDTH 1, 8 and 32 adders in lockstep
module tb_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1))  bus1 ();
  full_adder_if #(.WIDTH(8))  bus8 ();
  full_adder_if #(.WIDTH(32)) bus32 ();

  full_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
  full_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  full_adder #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

  logic [64:0] q1 [$];
  logic [64:0] q8 [$];
  logic [64:0] q32 [$];
  logic [64:0] held [3];

  function automatic int wid(input int k);
    return (k == 0) ? 1 : (k == 1) ? 8 : 32;
  endfunction

  task automatic check_dut(input int k, input string tag, input logic exp_ov);
    logic        ov;
    logic [64:0] obs;
    int          depth;
    case (k)
      0: begin ov = bus1.out_valid;  obs = 65'({bus1.c, bus1.s});   depth = q1.size();  end
      1: begin ov = bus8.out_valid;  obs = 65'({bus8.c, bus8.s});   depth = q8.size();  end
      default: begin ov = bus32.out_valid; obs = 65'({bus32.c, bus32.s}); depth = q32.size(); end
    endcase
    tests++;
    assert (ov === exp_ov) else begin
      fails++;
      $error("FAIL %s_w%0d_valid: got %b expected %b", tag, wid(k), ov, exp_ov);
    end
    if (ov === 1'b1) begin
      tests++;
      assert (depth > 0) else begin
        fails++;
        $error("FAIL %s_w%0d_unexpected: got out_valid with %0d queued expected >0", tag, wid(k), depth);
      end
      if (depth > 0) begin
        case (k)
          0: held[0] = q1.pop_front();
          1: held[1] = q8.pop_front();
          default: held[2] = q32.pop_front();
        endcase
      end
    end
    tests++;
    assert (obs === held[k]) else begin
      fails++;
      $error("FAIL %s_w%0d_sum: got %h expected %h", tag, wid(k), obs, held[k]);
    end
  endtask

  task automatic step(input logic v, input logic [63:0] av, input logic [63:0] bv,
                      input logic ci, input logic r, input string tag);
    rst = r;
    bus1.in_valid = v;  bus1.a = av[0];      bus1.b = bv[0];      bus1.cin = ci;
    bus8.in_valid = v;  bus8.a = av[7:0];    bus8.b = bv[7:0];    bus8.cin = ci;
    bus32.in_valid = v; bus32.a = av[31:0];  bus32.b = bv[31:0];  bus32.cin = ci;
    if (v && !r) begin
      q1.push_back(65'(av[0]) + 65'(bv[0]) + 65'(ci));
      q8.push_back(65'(av[7:0]) + 65'(bv[7:0]) + 65'(ci));
      q32.push_back(65'(av[31:0]) + 65'(bv[31:0]) + 65'(ci));
    end
    @(posedge clk);
    #1;
    if (r) begin
      q1.delete(); q8.delete(); q32.delete();
      for (int k = 0; k < 3; k++) held[k] = '0;
    end
    for (int k = 0; k < 3; k++) check_dut(k, tag, v && !r);
  endtask

  initial begin
    logic [1:0] tt [8];
    logic [7:0] lit;
    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int k = 0; k < 3; k++) held[k] = '0;
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, "reset");
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, "reset");

    for (int i = 0; i < 8; i++) begin
      lit = 8'(i);
      step(1'b1, 64'(lit[2]), 64'(lit[1]), lit[0], 1'b0, "truth");
      tests++;
      assert ({bus1.c, bus1.s} === tt[i]) else begin
        fails++;
        $error("FAIL truth_table_%0d: got %b expected %b", i, {bus1.c, bus1.s}, tt[i]);
      end
    end

    step(1'b1, 64'hFF, 64'h01, 1'b0, 1'b0, "carry_ff_01");
    tests++;
    assert ({bus8.c, bus8.s} === 9'h100) else begin
      fails++; $error("FAIL carry_ff_01_lit: got %h expected %h", {bus8.c, bus8.s}, 9'h100);
    end
    step(1'b1, 64'hFF, 64'h00, 1'b1, 1'b0, "carry_ff_cin");
    step(1'b1, 64'h7F, 64'h01, 1'b0, 1'b0, "carry_7f_01");
    tests++;
    assert ({bus8.c, bus8.s} === 9'h080) else begin
      fails++; $error("FAIL carry_7f_01_lit: got %h expected %h", {bus8.c, bus8.s}, 9'h080);
    end
    step(1'b1, 64'hFF, 64'hFF, 1'b1, 1'b0, "max");
    tests++;
    assert ({bus8.c, bus8.s} === 9'h1FF) else begin
      fails++; $error("FAIL max_lit: got %h expected %h", {bus8.c, bus8.s}, 9'h1FF);
    end
    step(1'b1, 64'h0, 64'h0, 1'b0, 1'b0, "zero");

    step(1'b1, 64'h3C, 64'h0F, 1'b0, 1'b0, "gate_load");
    step(1'b0, 64'hAA, 64'h55, 1'b0, 1'b0, "gate_hold");
    tests++;
    assert ({bus8.c, bus8.s} === 9'h04B) else begin
      fails++; $error("FAIL gate_hold_lit: got %h expected %h", {bus8.c, bus8.s}, 9'h04B);
    end
    step(1'b0, 64'hx, 64'hx, 1'bx, 1'b0, "gate_x");

    step(1'b1, 64'h10, 64'h20, 1'b0, 1'b1, "rst_same");
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, "rst_same_next");
    step(1'b1, 64'h12, 64'h34, 1'b1, 1'b0, "rst_after_load");
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, "rst_after_clear");
    step(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, "rst_after_idle");
    step(1'b1, 64'h5, 64'h6, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 1200; i++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 1)), 1'b0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
